// File: rtl/imu_pkg.sv
// imu_pkg: frame constants, parser/receiver state encodings and the saturating
// counter helper shared by the IMU telemetry receiver.
package imu_pkg;

  localparam logic [7:0] IMU_HDR        = 8'h55;
  localparam int         IMU_DATA_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TYPE = 2'd1,
    DATA = 2'd2,
    SUM  = 2'd3
  } parse_state_t;

  typedef enum logic [2:0] {
    RX_ARM   = 3'd0,
    RX_IDLE  = 3'd1,
    RX_START = 3'd2,
    RX_DATA  = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/uart_rx_os.sv
// uart_rx_os: double-flop synchronised, OVERSAMPLE-times oversampled 8N1 receiver.
// After reset it arms only once the line has idled high for one full bit time.
module uart_rx_os
  import imu_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk_uart,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int            CW      = $clog2(OVERSAMPLE) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  rx_state_t     state, state_nxt;
  logic          sync1, rx, rx_prev;
  logic [CW-1:0] tick, tick_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          byte_valid_nxt, frame_err_nxt;

  assign rx_byte = shreg;

  // Synchroniser, edge history and receiver state registers
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      rx         <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_ARM;
      tick       <= {CW{1'b0}};
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rx_pin;
      rx         <= sync1;
      rx_prev    <= rx;
      state      <= state_nxt;
      tick       <= tick_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      byte_valid <= byte_valid_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // Bit timing: start check at half a bit, then sample every bit centre
  always_comb begin
    state_nxt      = state;
    tick_nxt       = tick;
    bit_nxt        = bit_cnt;
    shreg_nxt      = shreg;
    byte_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    case (state)
      RX_ARM: begin
        if (!rx) begin
          tick_nxt = {CW{1'b0}};
        end else if (tick == FULL_M1) begin
          tick_nxt  = {CW{1'b0}};
          state_nxt = RX_IDLE;
        end else begin
          tick_nxt = tick + CW'(1);
        end
      end
      RX_IDLE: begin
        if (rx_prev && !rx) begin
          state_nxt = RX_START;
          tick_nxt  = {CW{1'b0}};
        end else begin
          state_nxt = RX_IDLE;
        end
      end
      RX_START: begin
        if (tick == HALF_M1) begin
          tick_nxt = {CW{1'b0}};
          bit_nxt  = 3'd0;
          if (rx) begin
            state_nxt = RX_IDLE;
          end else begin
            state_nxt = RX_DATA;
          end
        end else begin
          tick_nxt = tick + CW'(1);
        end
      end
      RX_DATA: begin
        if (tick == FULL_M1) begin
          tick_nxt  = {CW{1'b0}};
          shreg_nxt = {rx, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_nxt = RX_STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end else begin
          tick_nxt = tick + CW'(1);
        end
      end
      RX_STOP: begin
        if (tick == FULL_M1) begin
          tick_nxt  = {CW{1'b0}};
          state_nxt = RX_IDLE;
          if (rx) begin
            byte_valid_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end else begin
          tick_nxt = tick + CW'(1);
        end
      end
      default: begin
        state_nxt = RX_ARM;
        tick_nxt  = {CW{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/imu_frame_rx.sv
// imu_frame_rx: parses 11-byte 0x55-headed IMU frames and routes selected 16-bit words
// to NUM_CH channels. Define IMU_ERR_CNT_EN to add the err_sum/err_frame counters.
module imu_frame_rx
  import imu_pkg::*;
#(
  parameter int                  OVERSAMPLE   = 8,
  parameter int                  NUM_CH       = 2,
  parameter logic [NUM_CH*8-1:0] CH_TYPE      = 16'h5351,
  parameter logic [NUM_CH*2-1:0] CH_WORD      = 4'b0100,
  parameter int                  TIMEOUT_BITS = 20
) (
  input  logic                       clk_uart,
  input  logic                       rst_n,
  input  logic                       wireless_tx,
  output logic                       wireless_rx,
  output logic                       wireless_set,
  output logic signed [NUM_CH*16-1:0] ch_data,
  output logic [NUM_CH-1:0]          ch_valid
`ifdef IMU_ERR_CNT_EN
  ,
  output logic [7:0]                 err_sum,
  output logic [7:0]                 err_frame
`endif
);

  localparam int            TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int            TW       = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_M1    = TW'(TO_LIMIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(IMU_DATA_BYTES - 1);

  logic [7:0]   rx_byte;
  logic         byte_valid, frame_err;
  parse_state_t state, state_nxt;
  logic [2:0]   idx, idx_nxt;
  logic [7:0]   chk, chk_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic [7:0]   type_r;
  logic [7:0]   data_b [IMU_DATA_BYTES];
  logic         commit, sum_bad, abort;

  assign wireless_rx  = 1'b1;
  assign wireless_set = 1'b1;

  uart_rx_os #(.OVERSAMPLE(OVERSAMPLE)) u_rx (
    .clk_uart   (clk_uart),
    .rst_n      (rst_n),
    .rx_pin     (wireless_tx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // Parser state, running checksum, inter-byte timeout and captured frame bytes
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 3'd0;
      chk    <= 8'd0;
      to_cnt <= {TW{1'b0}};
      type_r <= 8'd0;
      for (int i = 0; i < IMU_DATA_BYTES; i++) data_b[i] <= 8'd0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      chk    <= chk_nxt;
      to_cnt <= to_nxt;
      if (byte_valid && state == TYPE) type_r <= rx_byte;
      if (byte_valid && state == DATA) data_b[idx] <= rx_byte;
    end
  end

  // Next-state: framing errors and timeouts abort any partial frame immediately
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    chk_nxt   = chk;
    to_nxt    = to_cnt;
    commit    = 1'b0;
    sum_bad   = 1'b0;
    abort     = 1'b0;
    if (frame_err) begin
      state_nxt = IDLE;
      abort     = 1'b1;
      to_nxt    = {TW{1'b0}};
    end else if (byte_valid) begin
      to_nxt = {TW{1'b0}};
      case (state)
        IDLE: begin
          if (rx_byte == IMU_HDR) begin
            state_nxt = TYPE;
            chk_nxt   = rx_byte;
          end else begin
            state_nxt = IDLE;
          end
        end
        TYPE: begin
          state_nxt = DATA;
          idx_nxt   = 3'd0;
          chk_nxt   = chk + rx_byte;
        end
        DATA: begin
          chk_nxt = chk + rx_byte;
          idx_nxt = idx + 3'd1;
          if (idx == LAST_IDX) begin
            state_nxt = SUM;
          end else begin
            state_nxt = DATA;
          end
        end
        SUM: begin
          state_nxt = IDLE;
          if (rx_byte == chk) begin
            commit = 1'b1;
          end else begin
            sum_bad = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (to_cnt == TO_M1) begin
        state_nxt = IDLE;
        abort     = 1'b1;
        to_nxt    = {TW{1'b0}};
      end else begin
        to_nxt = to_cnt + TW'(1);
      end
    end else begin
      to_nxt = {TW{1'b0}};
    end
  end

  // Channel routing: every matching channel loads its little-endian word together
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      ch_data  <= {(NUM_CH*16){1'b0}};
      ch_valid <= {NUM_CH{1'b0}};
    end else begin
      ch_valid <= {NUM_CH{1'b0}};
      if (commit) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (type_r == CH_TYPE[8*i +: 8]) begin
            ch_data[16*i +: 16] <= {data_b[{CH_WORD[2*i +: 2], 1'b1}],
                                    data_b[{CH_WORD[2*i +: 2], 1'b0}]};
            ch_valid[i]         <= 1'b1;
          end
        end
      end
    end
  end

`ifdef IMU_ERR_CNT_EN
  // Saturating checksum and framing/timeout error counters
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      err_sum   <= 8'd0;
      err_frame <= 8'd0;
    end else begin
      if (sum_bad) err_sum <= sat_inc8(err_sum);
      if (abort) err_frame <= sat_inc8(err_frame);
    end
  end
`else
  logic unused_err;
  assign unused_err = sum_bad ^ abort;
`endif

endmodule

// File: tb/tb_imu_frame_rx.sv
// tb_imu_frame_rx: drives UART frames into a default and a 3-channel receiver and
// compares channel data, strobes and error counts against a frame-level model.
module tb_imu_frame_rx;

  localparam int BIT = 80;  // one bit time: OVERSAMPLE cycles of 10 time units

  logic clk_uart = 1'b0;
  logic rst_n;
  logic wireless_tx;
  logic rx_a, set_a, rx_b, set_b;
  logic signed [31:0] data_a;
  logic [1:0]         valid_a;
  logic signed [47:0] data_b;
  logic [2:0]         valid_b;
`ifdef IMU_ERR_CNT_EN
  logic [7:0] esum_a, eframe_a, esum_b, eframe_b;
`endif

  always #5 clk_uart = ~clk_uart;

  imu_frame_rx dut_a (
    .clk_uart(clk_uart), .rst_n(rst_n), .wireless_tx(wireless_tx),
    .wireless_rx(rx_a), .wireless_set(set_a), .ch_data(data_a), .ch_valid(valid_a)
`ifdef IMU_ERR_CNT_EN
    , .err_sum(esum_a), .err_frame(eframe_a)
`endif
  );

  imu_frame_rx #(.NUM_CH(3), .CH_TYPE(24'h515151), .CH_WORD(6'b100100)) dut_b (
    .clk_uart(clk_uart), .rst_n(rst_n), .wireless_tx(wireless_tx),
    .wireless_rx(rx_b), .wireless_set(set_b), .ch_data(data_b), .ch_valid(valid_b)
`ifdef IMU_ERR_CNT_EN
    , .err_sum(esum_b), .err_frame(eframe_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model state (frame level)
  logic [15:0] exp_a [2];
  logic [15:0] exp_b [3];
  int exp_pa [2];
  int exp_pb [3];
  int exp_all_b = 0;
  int exp_esum = 0;
  int exp_eframe = 0;

  // strobe monitor
  int pul_a [2];
  int hi_a  [2];
  int pul_b [3];
  int hi_b  [3];
  int all_b = 0;
  logic [1:0] prev_a = 2'b00;
  logic [2:0] prev_b = 3'b000;

  initial begin
    for (int i = 0; i < 2; i++) begin pul_a[i] = 0; hi_a[i] = 0; exp_pa[i] = 0; end
    for (int i = 0; i < 3; i++) begin pul_b[i] = 0; hi_b[i] = 0; exp_pb[i] = 0; end
  end

  always @(negedge clk_uart) begin
    for (int i = 0; i < 2; i++) begin
      if (valid_a[i]) hi_a[i] <= hi_a[i] + 1;
      if (valid_a[i] && !prev_a[i]) pul_a[i] <= pul_a[i] + 1;
    end
    for (int i = 0; i < 3; i++) begin
      if (valid_b[i]) hi_b[i] <= hi_b[i] + 1;
      if (valid_b[i] && !prev_b[i]) pul_b[i] <= pul_b[i] + 1;
    end
    if (&valid_b) all_b <= all_b + 1;
    prev_a <= valid_a;
    prev_b <= valid_b;
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) exp_a[i] = 16'h0000;
    for (int i = 0; i < 3; i++) exp_b[i] = 16'h0000;
    exp_esum = 0;
    exp_eframe = 0;
  endtask

  // A complete frame: channel A0 takes type 0x51 word 0, A1 type 0x53 word 1;
  // every B channel takes type 0x51, word i.
  task automatic model_frame(input logic [7:0] t, input logic [63:0] w, input bit ok);
    if (!ok) begin
      if (exp_esum < 255) exp_esum++;
    end else begin
      if (t == 8'h51) begin exp_a[0] = w[15:0];  exp_pa[0]++; end
      if (t == 8'h53) begin exp_a[1] = w[31:16]; exp_pa[1]++; end
      if (t == 8'h51) begin
        for (int i = 0; i < 3; i++) begin exp_b[i] = w[16*i +: 16]; exp_pb[i]++; end
        exp_all_b++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
    wireless_tx = 1'b0;
    #(BIT);
    for (int k = 0; k < 8; k++) begin wireless_tx = b[k]; #(BIT); end
    wireless_tx = stop_ok;
    #(BIT);
    wireless_tx = 1'b1;
    #(BIT * gap_bits);
  endtask

  task automatic send_frame(input logic [7:0] t, input logic [63:0] w, input logic [7:0] delta,
                            input int nbytes, input int bad_idx, input int gap_bits);
    logic [7:0] fb [11];
    logic [7:0] s;
    fb[0] = 8'h55;
    fb[1] = t;
    for (int k = 0; k < 8; k++) fb[2+k] = w[8*k +: 8];
    s = 8'h00;
    for (int k = 0; k < 10; k++) s = s + fb[k];
    fb[10] = s + delta;
    for (int k = 0; k < nbytes; k++) send_byte(fb[k], k != bad_idx, gap_bits);
  endtask

  localparam logic [63:0] W_A = {16'hcdef, 16'h89ab, 16'h4567, 16'h0123};
  localparam logic [63:0] W_C = {16'h3210, 16'h7654, 16'hba98, 16'hfedc};

  task automatic test_reset();
    rst_n = 1'b0;
    wireless_tx = 1'b1;
    model_reset();
    #(BIT);
    checks++;
    if (data_a !== 32'sd0 || valid_a !== 2'b00 || data_b !== 48'sd0 || valid_b !== 3'b000 ||
        rx_a !== 1'b1 || set_a !== 1'b1 || rx_b !== 1'b1 || set_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_state data_a=%h valid_a=%b data_b=%h rx=%b set=%b (want 0,0,0,1,1)",
               data_a, valid_a, data_b, rx_a, set_a);
    end
    rst_n = 1'b1;
    #(BIT * 2);
`ifdef IMU_ERR_CNT_EN
    checks++;
    if (esum_a !== 8'd0 || eframe_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_counters err_sum=%0d err_frame=%0d want 0 0", esum_a, eframe_a);
    end
`endif
    checks++;
    if (data_a !== 32'sd0 || valid_a !== 2'b00) begin
      errors++;
      $display("FAIL reset_release data_a=%h valid_a=%b want 0", data_a, valid_a);
    end
  endtask

  task automatic test_basic();
    send_frame(8'h51, W_A, 8'd0, 11, -1, 1);
    model_frame(8'h51, W_A, 1'b1);
    #(BIT);
    checks++;
    if (data_a[15:0] !== 16'h0123 || data_a[31:16] !== 16'h0000) begin
      errors++;
      $display("FAIL basic_words ch0=%h ch1=%h want 0123 0000", data_a[15:0], data_a[31:16]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (data_a[16*i +: 16] !== exp_a[i] || pul_a[i] !== exp_pa[i] || hi_a[i] !== exp_pa[i]) begin
        errors++;
        $display("FAIL basic_ch%0d data=%h want %h pulses=%0d high=%0d want %0d",
                 i, data_a[16*i +: 16], exp_a[i], pul_a[i], hi_a[i], exp_pa[i]);
      end
    end
  endtask

  task automatic test_type_route();
    send_frame(8'h52, W_A, 8'd0, 11, -1, 1);
    model_frame(8'h52, W_A, 1'b1);
    send_byte(8'h76, 1'b1, 1);
    send_frame(8'h53, W_A, 8'd0, 11, -1, 1);
    model_frame(8'h53, W_A, 1'b1);
    #(BIT);
    checks++;
    if (data_a[31:16] !== 16'h4567 || pul_a[1] !== 1) begin
      errors++;
      $display("FAIL route_ch1 data=%h pulses=%0d want 4567 1", data_a[31:16], pul_a[1]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (data_a[16*i +: 16] !== exp_a[i] || pul_a[i] !== exp_pa[i] || hi_a[i] !== exp_pa[i]) begin
        errors++;
        $display("FAIL route_ch%0d data=%h want %h pulses=%0d high=%0d want %0d",
                 i, data_a[16*i +: 16], exp_a[i], pul_a[i], hi_a[i], exp_pa[i]);
      end
    end
  endtask

  task automatic test_checksum();
    send_frame(8'h53, W_C, 8'd1, 11, -1, 1);
    model_frame(8'h53, W_C, 1'b0);
    #(BIT);
    checks++;
    if (data_a[31:16] !== exp_a[1] || pul_a[1] !== exp_pa[1]) begin
      errors++;
      $display("FAIL sum_bad_no_update ch1=%h pulses=%0d want %h %0d",
               data_a[31:16], pul_a[1], exp_a[1], exp_pa[1]);
    end
`ifdef IMU_ERR_CNT_EN
    checks++;
    if (esum_a !== 8'(exp_esum) || eframe_a !== 8'(exp_eframe)) begin
      errors++;
      $display("FAIL sum_bad_count err_sum=%0d err_frame=%0d want %0d %0d",
               esum_a, eframe_a, exp_esum, exp_eframe);
    end
`endif
    send_frame(8'h53, W_C, 8'd0, 11, -1, 1);
    model_frame(8'h53, W_C, 1'b1);
    #(BIT);
    checks++;
    if (data_a[31:16] !== 16'hba98 || data_a[31:16] !== exp_a[1] || !($signed(data_a[31:16]) < 0)) begin
      errors++;
      $display("FAIL sum_ok_resend ch1=%h want ba98 (negative)", data_a[31:16]);
    end
  endtask

  task automatic test_framing();
    logic [63:0] w;
    w = {$urandom, $urandom};
    send_frame(8'h51, W_C, 8'd0, 4, 3, 1);
    if (exp_eframe < 255) exp_eframe++;
    send_frame(8'h51, w, 8'd0, 11, -1, 1);
    model_frame(8'h51, w, 1'b1);
    #(BIT);
    checks++;
    if (data_a[15:0] !== exp_a[0] || pul_a[0] !== exp_pa[0] || hi_a[0] !== exp_pa[0]) begin
      errors++;
      $display("FAIL framing_recover ch0=%h want %h pulses=%0d high=%0d want %0d",
               data_a[15:0], exp_a[0], pul_a[0], hi_a[0], exp_pa[0]);
    end
`ifdef IMU_ERR_CNT_EN
    checks++;
    if (eframe_a !== 8'(exp_eframe) || esum_a !== 8'(exp_esum)) begin
      errors++;
      $display("FAIL framing_count err_frame=%0d err_sum=%0d want %0d %0d",
               eframe_a, esum_a, exp_eframe, exp_esum);
    end
`endif
  endtask

  task automatic test_timeout();
    logic [63:0] w;
    w = {$urandom, $urandom};
    send_frame(8'h51, W_A, 8'd0, 5, -1, 1);
    #(BIT * 25);
    if (exp_eframe < 255) exp_eframe++;
    send_frame(8'h51, w, 8'd0, 11, -1, 1);
    model_frame(8'h51, w, 1'b1);
    #(BIT);
    checks++;
    if (data_a[15:0] !== exp_a[0] || pul_a[0] !== exp_pa[0]) begin
      errors++;
      $display("FAIL timeout_recover ch0=%h want %h pulses=%0d want %0d",
               data_a[15:0], exp_a[0], pul_a[0], exp_pa[0]);
    end
`ifdef IMU_ERR_CNT_EN
    checks++;
    if (eframe_a !== 8'(exp_eframe)) begin
      errors++;
      $display("FAIL timeout_count err_frame=%0d want %0d", eframe_a, exp_eframe);
    end
`endif
  endtask

  task automatic test_multi_channel();
    send_frame(8'h51, W_A, 8'd0, 11, -1, 1);
    model_frame(8'h51, W_A, 1'b1);
    #(BIT);
    checks++;
    if (data_b !== {16'h89ab, 16'h4567, 16'h0123} || all_b !== exp_all_b) begin
      errors++;
      $display("FAIL multi_words data_b=%h want 89ab45670123 together=%0d want %0d",
               data_b, all_b, exp_all_b);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pul_b[i] !== exp_pb[i] || hi_b[i] !== exp_pb[i]) begin
        errors++;
        $display("FAIL multi_strobe_ch%0d pulses=%0d high=%0d want %0d", i, pul_b[i], hi_b[i], exp_pb[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  t;
    logic [63:0] w;
    logic [7:0]  d;
    for (int n = 0; n < 12; n++) begin
      t = 8'h50 + 8'($urandom_range(0, 3));
      w = {$urandom, $urandom};
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      send_frame(t, w, d, 11, -1, $urandom_range(1, 5));
      model_frame(t, w, d == 8'd0);
      #(BIT);
      checks++;
      if (data_a !== {exp_a[1], exp_a[0]} || data_b !== {exp_b[2], exp_b[1], exp_b[0]} ||
          pul_a[0] !== exp_pa[0] || pul_a[1] !== exp_pa[1] || hi_a[1] !== exp_pa[1] ||
          pul_b[2] !== exp_pb[2] || all_b !== exp_all_b) begin
        errors++;
        $display("FAIL random_%0d type=%h data_a=%h want %h%h data_b=%h want %h%h%h",
                 n, t, data_a, exp_a[1], exp_a[0], data_b, exp_b[2], exp_b[1], exp_b[0]);
      end
`ifdef IMU_ERR_CNT_EN
      checks++;
      if (esum_a !== 8'(exp_esum) || esum_b !== 8'(exp_esum) || eframe_b !== 8'(exp_eframe)) begin
        errors++;
        $display("FAIL random_count_%0d err_sum=%0d/%0d want %0d", n, esum_a, esum_b, exp_esum);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] w;
    w = {$urandom, $urandom};
    send_frame(8'h53, W_C, 8'd0, 3, -1, 1);
    wireless_tx = 1'b0;
    #(BIT * 2);
    rst_n = 1'b0;
    model_reset();
    #(BIT);
    checks++;
    if (data_a !== 32'sd0 || data_b !== 48'sd0 || valid_a !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_clear data_a=%h data_b=%h want 0", data_a, data_b);
    end
    rst_n = 1'b1;
    #(BIT * 3);
    wireless_tx = 1'b1;
    #(BIT * 2);
    send_frame(8'h53, w, 8'd0, 11, -1, 1);
    model_frame(8'h53, w, 1'b1);
    #(BIT);
    checks++;
    if (data_a !== {exp_a[1], exp_a[0]} || pul_a[1] !== exp_pa[1] || hi_a[1] !== exp_pa[1]) begin
      errors++;
      $display("FAIL mid_reset_recover data_a=%h want %h%h pulses=%0d want %0d",
               data_a, exp_a[1], exp_a[0], pul_a[1], exp_pa[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_type_route();
    test_checksum();
    test_framing();
    test_timeout();
    test_multi_channel();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
